array_feeder_8: RTL and testbench
=================================

Name: array_feeder_8

Overview:
- Sequencer and skew generator that drives the control and data inputs of the 8x8 binary-parallel systolic array.
- Accepts one unskewed beat per accepted handshake. A beat is HEIGHT ifm words plus WIDTH weight words.
- Emits the beat as staircase-skewed ifm/wght streams with matching en_*/clr_* strobes.
- After the last beat, sequences the per-column en_o/clr_o drain that shifts results out of the array's ofm chain.

Parameters:
- HEIGHT, 8, array rows; width of en_i/clr_i and depth of ifm.
- WIDTH, 8, array columns; width of en_w/clr_w/en_o/clr_o and depth of wght.
- IWIDTH, 16, signed operand width.
- KW, 16, width of the reduction-length field k_len.

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  begin a tile; sampled only in IDLE
- k_len  input  KW  number of beats in the tile; sampled with start
- in_valid  input  1  upstream beat valid
- in_ready  output  1  beat accepted when in_valid & in_ready
- in_ifm  input  signed IWIDTH x [HEIGHT]  unpacked, one word per row
- in_wght  input  signed IWIDTH x [WIDTH]  unpacked, one word per column
- en_i, clr_i  output  HEIGHT  per-row input strobes to the array
- ifm  output  signed IWIDTH x [HEIGHT]  skewed row data
- en_w, clr_w  output  WIDTH  per-column weight strobes
- wght  output  signed IWIDTH x [WIDTH]  skewed column data
- en_o, clr_o  output  WIDTH  per-column output-drain strobes
- busy  output  1  high in every state except IDLE
- done  output  1  one-cycle pulse when the tile completes

Behaviour:
- Clock and reset: single clock domain. Async active-low reset.
- Reset values: all outputs 0, including in_ready, busy, done, strobes and data. All skew registers 0. FSM enters IDLE.
- States: IDLE, STREAM, FLUSH, DRAIN, DONE.
- IDLE:
  - start with k_len>=1: latch k_len, clear beat counter, go to STREAM.
  - start with k_len==0: go to DONE directly, with no strobes issued.
- STREAM:
  - in_ready=1.
  - Each accepted beat increments the beat counter. The beat with index 0 carries clr.
  - Accepting beat k_len-1 moves the FSM to FLUSH on the next cycle.
  - Cycles with in_valid=0 inject a bubble (en=0) into the skew lines. The beat counter does not advance.
- Skew:
  - A beat accepted in cycle t appears on row h (en_i[h], clr_i[h], ifm[h]) in cycle t+1+h.
  - The same beat appears on column w (en_w[w], clr_w[w], wght[w]) in cycle t+1+w.
  - All outputs are registered. Implement with triangular shift-register delay lines.
  - clr_x is asserted only together with en_x, and only for beat 0.
- FLUSH:
  - in_ready=0.
  - Lasts exactly HEIGHT+WIDTH-1 cycles. This lets the last beat leave the skew lines and reach PE[HEIGHT-1][WIDTH-1].
  - Skew lines keep shifting, with bubbles entering at the head.
- DRAIN: lasts WIDTH+HEIGHT cycles, numbered d=0..WIDTH+HEIGHT-1.
  - en_o[w]=1 for d in [w, w+HEIGHT-1].
  - clr_o[w]=1 only at d=w+HEIGHT.
  - The two are never high together on one column.
- DONE: done=1 for one cycle, then return to IDLE.
- start outside IDLE is ignored. in_valid outside STREAM is ignored.
- Reset asserted mid-tile: everything returns to reset values immediately. The partial tile is abandoned, and no done pulse is produced.
- The beat counter is KW bits wide. It compares against the latched k_len and never wraps, since k_len<=2^KW-1.

Optional Feature:
- Macro: FEEDER_ZERO_GATE_EN.
- When defined: ifm[h] and wght[w] are forced to 0 in any cycle where the matching en_i[h]/en_w[w] is 0. This covers bubbles, FLUSH, DRAIN and IDLE, and cuts toggle power in the array.
- When undefined: data outputs carry whatever value the skew register holds, including stale data under en=0. The reset value is still 0.

Test Plan:
- Reset: hold rst_n=0 with random inputs -> every output 0, in_ready=0, busy=0. Release rst_n -> FSM in IDLE, outputs stay 0.
- Basic skew: start, k_len=3, in_valid held 1, in_ifm[h]=16*b+h for beat b; first accept at cycle t.
  - Row 5 shows ifm=5,21,37 at t+6..t+8.
  - en_i[5]=1 for those three cycles; clr_i[5]=1 only at t+6.
  - Column 7: en_w[7] for t+8..t+10.
- Bubble: k_len=4, in_valid low for one cycle after beat 1 -> every row/column shows a one-cycle en gap at its skewed position. Exactly 4 en pulses per row. FLUSH starts after the 4th accept.
- Drain timing: after the last accept, FLUSH lasts exactly 15 cycles.
  - Then en_o[0] high for DRAIN cycles 0..7, clr_o[0] at 8.
  - en_o[7] high for 7..14, clr_o[7] at 15.
  - done pulses one cycle after DRAIN cycle 15. busy falls in the same cycle done falls.
- k_len=0: start -> done=1 for one cycle, with no en_* or clr_* activity. start pulsed during busy is ignored.
- Reset mid-STREAM after 2 of 5 beats -> all outputs 0 next edge, no done. A new start with k_len=2 then completes normally.
- With FEEDER_ZERO_GATE_EN defined: during the bubble test, ifm/wght read 0 in en=0 cycles. Without the macro, they hold the last shifted value.

Source files
------------

// File: rtl/array_feeder_8.sv
// Sequencer and staircase skew generator feeding the 8x8 systolic array, plus the ofm drain.
// Optional FEEDER_ZERO_GATE_EN: zero skewed data whenever the matching enable is low.
module array_feeder_8 #(
  parameter int HEIGHT = 8,
  parameter int WIDTH  = 8,
  parameter int IWIDTH = 16,
  parameter int KW     = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic        [KW-1:0]     k_len,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [IWIDTH-1:0] in_ifm  [HEIGHT],
  input  logic signed [IWIDTH-1:0] in_wght [WIDTH],
  output logic        [HEIGHT-1:0] en_i,
  output logic        [HEIGHT-1:0] clr_i,
  output logic signed [IWIDTH-1:0] ifm     [HEIGHT],
  output logic        [WIDTH-1:0]  en_w,
  output logic        [WIDTH-1:0]  clr_w,
  output logic signed [IWIDTH-1:0] wght    [WIDTH],
  output logic        [WIDTH-1:0]  en_o,
  output logic        [WIDTH-1:0]  clr_o,
  output logic                     busy,
  output logic                     done
);

  typedef enum logic [2:0] {S_IDLE, S_STREAM, S_FLUSH, S_DRAIN, S_DONE} state_e;

  localparam logic [KW-1:0] FLUSH_LAST = KW'(HEIGHT + WIDTH - 2);
  localparam logic [KW-1:0] DRAIN_LAST = KW'(HEIGHT + WIDTH - 1);

  state_e            state_q, state_d;
  logic [KW-1:0]     cnt_q, cnt_d;
  logic [KW-1:0]     klen_q, klen_d;
  logic              in_ready_q, busy_q, done_q;
  logic [WIDTH-1:0]  en_o_q, en_o_d, clr_o_q, clr_o_d;
  logic              accept, first_beat;

  assign accept     = in_valid & in_ready_q;
  assign first_beat = accept & (cnt_q == '0);

  // cnt_q counts beats in STREAM and phase cycles in FLUSH/DRAIN.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
    state_d = state_q;
    cnt_d   = cnt_q;
    klen_d  = klen_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (k_len == '0) begin
            state_d = S_DONE;
          end else begin
            state_d = S_STREAM;
            klen_d  = k_len;
            cnt_d   = '0;
          end
        end
      end
      S_STREAM: begin
        if (accept) begin
          if (cnt_q == klen_q - KW'(1)) begin
            state_d = S_FLUSH;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + KW'(1);
          end
        end
      end
      S_FLUSH: begin
        if (cnt_q == FLUSH_LAST) begin
          state_d = S_DRAIN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + KW'(1);
        end
      end
      S_DRAIN: begin
        if (cnt_q == DRAIN_LAST) begin
          state_d = S_DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + KW'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Drain strobes are decoded from the next phase so they come out registered in step.
  always_comb begin
    en_o_d  = '0;
    clr_o_d = '0;
    if (state_d == S_DRAIN) begin
      for (int w = 0; w < WIDTH; w++) begin
        en_o_d[w]  = (32'(cnt_d) >= 32'(w)) && (32'(cnt_d) <= 32'(w + HEIGHT - 1));
        clr_o_d[w] = (32'(cnt_d) == 32'(w + HEIGHT));
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      klen_q     <= '0;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      en_o_q     <= '0;
      clr_o_q    <= '0;
    end else begin
      // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      klen_q     <= klen_d;
      in_ready_q <= (state_d == S_STREAM);
      busy_q     <= (state_d != S_IDLE);
      done_q     <= (state_d == S_DONE);
      en_o_q     <= en_o_d;
      clr_o_q    <= clr_o_d;
    end
  end

  assign in_ready = in_ready_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign en_o     = en_o_q;
  assign clr_o    = clr_o_q;

  // Row h delay line has h+1 stages, so a beat accepted at t shows at t+1+h.
  for (genvar h = 0; h < HEIGHT; h++) begin : g_row
    logic                     en_sr  [h+1];
    logic                     clr_sr [h+1];
    logic signed [IWIDTH-1:0] dat_sr [h+1];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        // NOTE: the skew arrays must come out of reset as zero, so they are reset element by element.
        for (int s = 0; s <= h; s++) begin
          en_sr[s]  <= 1'b0;
          clr_sr[s] <= 1'b0;
          dat_sr[s] <= '0;
        end
      end else begin
        en_sr[0]  <= accept;
        clr_sr[0] <= first_beat;
`ifdef FEEDER_ZERO_GATE_EN
        dat_sr[0] <= accept ? in_ifm[h] : '0;
`else
        if (accept) dat_sr[0] <= in_ifm[h];
`endif
        for (int s = 1; s <= h; s++) begin
          en_sr[s]  <= en_sr[s-1];
          clr_sr[s] <= clr_sr[s-1];
          dat_sr[s] <= dat_sr[s-1];
        end
      end
    end

    assign en_i[h]  = en_sr[h];
    assign clr_i[h] = clr_sr[h];
    assign ifm[h]   = dat_sr[h];
  end

  for (genvar w = 0; w < WIDTH; w++) begin : g_col
    logic                     en_sr  [w+1];
    logic                     clr_sr [w+1];
    logic signed [IWIDTH-1:0] dat_sr [w+1];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int s = 0; s <= w; s++) begin
          en_sr[s]  <= 1'b0;
          clr_sr[s] <= 1'b0;
          dat_sr[s] <= '0;
        end
      end else begin
        en_sr[0]  <= accept;
        clr_sr[0] <= first_beat;
`ifdef FEEDER_ZERO_GATE_EN
        dat_sr[0] <= accept ? in_wght[w] : '0;
`else
        if (accept) dat_sr[0] <= in_wght[w];
`endif
        for (int s = 1; s <= w; s++) begin
          en_sr[s]  <= en_sr[s-1];
          clr_sr[s] <= clr_sr[s-1];
          dat_sr[s] <= dat_sr[s-1];
        end
      end
    end

    assign en_w[w]  = en_sr[w];
    assign clr_w[w] = clr_sr[w];
    assign wght[w]  = dat_sr[w];
  end

endmodule

// File: tb/tb_array_feeder_8.sv
// Scoreboard bench for array_feeder_8: stimulus queues expected strobes, a negedge monitor pops and compares.
module tb_array_feeder_8;

  localparam int H  = 8;
  localparam int W  = 8;
  localparam int IW = 16;
  localparam int KW = 16;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 start = 1'b0;
  logic        [KW-1:0] k_len = '0;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic signed [IW-1:0] in_ifm  [H];
  logic signed [IW-1:0] in_wght [W];
  logic        [H-1:0]  en_i, clr_i;
  logic signed [IW-1:0] ifm  [H];
  logic        [W-1:0]  en_w, clr_w;
  logic signed [IW-1:0] wght [W];
  logic        [W-1:0]  en_o, clr_o;
  logic                 busy, done;

  array_feeder_8 dut (
    .clk(clk), .rst_n(rst_n), .start(start), .k_len(k_len),
    .in_valid(in_valid), .in_ready(in_ready), .in_ifm(in_ifm), .in_wght(in_wght),
    .en_i(en_i), .clr_i(clr_i), .ifm(ifm), .en_w(en_w), .clr_w(clr_w), .wght(wght),
    .en_o(en_o), .clr_o(clr_o), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int                   cyc;
    logic                 clr;
    logic signed [IW-1:0] dat;
  } beat_t;

  beat_t row_q  [H][$];
  beat_t col_q  [W][$];
  int    eno_q  [W][$];
  int    clro_q [W][$];
  int    done_q [$];

  logic signed [IW-1:0] last_i [H];
  logic signed [IW-1:0] last_w [W];

  task automatic check(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  function automatic bit all_zero();
    bit z;
    z = !(|en_i || |clr_i || |en_w || |clr_w || |en_o || |clr_o || busy || done || in_ready);
    for (int h = 0; h < H; h++) if (ifm[h] != '0) z = 1'b0;
    for (int w = 0; w < W; w++) if (wght[w] != '0) z = 1'b0;
    return z;
  endfunction

  // Monitor: every strobe must match the head of its queue; idle data must be stale (or zero when gated).
  always @(negedge clk) begin
    beat_t e;
    int    c;
    if (!rst_n) begin
      for (int h = 0; h < H; h++) last_i[h] = '0;
      for (int w = 0; w < W; w++) last_w[w] = '0;
    end else begin
      for (int h = 0; h < H; h++) begin
        if (en_i[h]) begin
          if (row_q[h].size() == 0) begin
            check($sformatf("row%0d unexpected en_i", h), en_i[h], 0);
          end else begin
            e = row_q[h].pop_front();
            check($sformatf("row%0d en_i cycle", h), cyc, e.cyc);
            check($sformatf("row%0d clr_i", h), clr_i[h], e.clr);
            check($sformatf("row%0d ifm", h), ifm[h], e.dat);
            last_i[h] = e.dat;
          end
        end else begin
          check($sformatf("row%0d clr_i without en_i", h), clr_i[h], 0);
`ifdef FEEDER_ZERO_GATE_EN
          check($sformatf("row%0d gated ifm", h), ifm[h], 0);
`else
          check($sformatf("row%0d stale ifm", h), ifm[h], last_i[h]);
`endif
        end
      end
      for (int w = 0; w < W; w++) begin
        if (en_w[w]) begin
          if (col_q[w].size() == 0) begin
            check($sformatf("col%0d unexpected en_w", w), en_w[w], 0);
          end else begin
            e = col_q[w].pop_front();
            check($sformatf("col%0d en_w cycle", w), cyc, e.cyc);
            check($sformatf("col%0d clr_w", w), clr_w[w], e.clr);
            check($sformatf("col%0d wght", w), wght[w], e.dat);
            last_w[w] = e.dat;
          end
        end else begin
          check($sformatf("col%0d clr_w without en_w", w), clr_w[w], 0);
`ifdef FEEDER_ZERO_GATE_EN
          check($sformatf("col%0d gated wght", w), wght[w], 0);
`else
          check($sformatf("col%0d stale wght", w), wght[w], last_w[w]);
`endif
        end
        check($sformatf("col%0d en_o and clr_o together", w), en_o[w] & clr_o[w], 0);
        if (en_o[w]) begin
          if (eno_q[w].size() == 0) check($sformatf("col%0d unexpected en_o", w), en_o[w], 0);
          else begin c = eno_q[w].pop_front(); check($sformatf("col%0d en_o cycle", w), cyc, c); end
        end
        if (clr_o[w]) begin
          if (clro_q[w].size() == 0) check($sformatf("col%0d unexpected clr_o", w), clr_o[w], 0);
          else begin c = clro_q[w].pop_front(); check($sformatf("col%0d clr_o cycle", w), cyc, c); end
        end
      end
      if (done) begin
        if (done_q.size() == 0) check("unexpected done", done, 0);
        else begin
          c = done_q.pop_front();
          check("done cycle", cyc, c);
          check("busy with done", busy, 1);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_beat(input int b);
    for (int h = 0; h < H; h++) in_ifm[h] = IW'(16 * b + h);
    for (int w = 0; w < W; w++) in_wght[w] = IW'(-(16 * b + w + 1));
  endtask

  task automatic push_beat(input int c, input int b);
    beat_t e;
    for (int h = 0; h < H; h++) begin
      e.cyc = c + 1 + h; e.clr = (b == 0); e.dat = IW'(16 * b + h);
      row_q[h].push_back(e);
    end
    for (int w = 0; w < W; w++) begin
      e.cyc = c + 1 + w; e.clr = (b == 0); e.dat = IW'(-(16 * b + w + 1));
      col_q[w].push_back(e);
    end
  endtask

  task automatic clear_queues();
    for (int h = 0; h < H; h++) row_q[h].delete();
    for (int w = 0; w < W; w++) begin
      col_q[w].delete(); eno_q[w].delete(); clro_q[w].delete();
    end
    done_q.delete();
  endtask

  task automatic check_empty(input string name);
    int left = done_q.size();
    for (int h = 0; h < H; h++) left += row_q[h].size();
    for (int w = 0; w < W; w++) left += col_q[w].size() + eno_q[w].size() + clro_q[w].size();
    check({name, " missing expected events"}, left, 0);
  endtask

  task automatic start_tile(input int k);
    start = 1'b1;
    k_len = KW'(k);
    step();
    start = 1'b0;
  endtask

  // vpat bit i gives in_valid for the i-th cycle after start.
  task automatic feed(input int n, input logic [31:0] vpat, output int t_last);
    int nacc = 0;
    int i = 0;
    t_last = cyc;
    while (nacc < n && i < 32) begin
      in_valid = vpat[i];
      set_beat(nacc);
      check("in_ready in STREAM", in_ready, 1);
      if (vpat[i]) begin
        push_beat(cyc, nacc);
        t_last = cyc;
        nacc++;
      end
      i++;
      step();
    end
  endtask

  // Entered at cycle t_last+1; in_valid stays high to show it is ignored after STREAM.
  task automatic finish_tile(input int t_last);
    int drain0 = t_last + H + W;
    check("in_ready after last beat", in_ready, 0);
    for (int w = 0; w < W; w++) begin
      for (int d = w; d < w + H; d++) eno_q[w].push_back(drain0 + d);
      clro_q[w].push_back(drain0 + w + H);
    end
    done_q.push_back(drain0 + H + W);
    while (cyc < t_last + 5) step();
    start = 1'b1;
    k_len = '0;
    step();
    start = 1'b0;
    check("busy in FLUSH", busy, 1);
    while (cyc < drain0 + H + W + 1) step();
    check("busy after done", busy, 0);
    check("done one cycle only", done, 0);
    in_valid = 1'b0;
    check_empty("tile");
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1);
  end

  initial begin
    int s;
    int t;

    for (int h = 0; h < H; h++) in_ifm[h] = '0;
    for (int w = 0; w < W; w++) in_wght[w] = '0;

    // Reset with random inputs
    for (int i = 0; i < 4; i++) begin
      start    = 1'($urandom);
      in_valid = 1'($urandom);
      k_len    = KW'($urandom);
      for (int h = 0; h < H; h++) in_ifm[h] = IW'($urandom);
      for (int w = 0; w < W; w++) in_wght[w] = IW'($urandom);
      step();
      check("outputs zero in reset", all_zero(), 1);
    end
    start = 1'b0;
    in_valid = 1'b0;
    rst_n = 1'b1;
    step();
    step();
    check("outputs zero after reset release", all_zero(), 1);

    // Basic skew, three back-to-back beats
    start_tile(3);
    feed(3, 32'hFFFF_FFFF, t);
    finish_tile(t);

    // One-cycle bubble after beat 1
    step();
    start_tile(4);
    feed(4, 32'h0000_001B, t);
    finish_tile(t);

    // k_len == 0, start held into the busy DONE cycle
    step();
    s = cyc;
    done_q.push_back(s + 1);
    start = 1'b1;
    k_len = '0;
    step();
    check("busy in DONE for k_len 0", busy, 1);
    step();
    start = 1'b0;
    check("busy after k_len 0", busy, 0);
    step();
    step();
    check_empty("k_len 0");

    // Reset after 2 of 5 beats, then a normal tile
    start_tile(5);
    feed(2, 32'hFFFF_FFFF, t);
    rst_n = 1'b0;
    #1;
    clear_queues();
    check("outputs zero on mid-tile reset", all_zero(), 1);
    in_valid = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) step();
    check("idle after mid-tile reset", busy, 0);
    check_empty("mid-tile reset");
    start_tile(2);
    feed(2, 32'hFFFF_FFFF, t);
    finish_tile(t);

    step();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
